// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down modulo counter family.
package counter_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_STOP   = 2'd0;
  localparam mode_t MODE_WRAP   = 2'd1;
  localparam mode_t MODE_RELOAD = 2'd2;

endpackage

// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with stop/wrap/reload terminal modes
// and a registered one-cycle terminal-count pulse; 1-cycle load/step latency.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE   = '1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             up,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             at_max,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be 1..32");
  end
  if (MAX_VALUE == '0) begin : g_bad_max
    $error("updown_mod_counter: MAX_VALUE must be at least 1");
  end
  if (RESET_VALUE > MAX_VALUE) begin : g_bad_reset
    $error("updown_mod_counter: RESET_VALUE must not exceed MAX_VALUE");
  end

  mode_t            mode_s;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] term_value;
  logic [WIDTH-1:0] step_value;
  logic             at_term;
  logic [WIDTH-1:0] counter_nxt;
  logic [WIDTH-1:0] reload_nxt;
  logic             tc_nxt;

  assign mode_s       = mode;
  assign load_clamped = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
  assign term_value   = up ? MAX_VALUE : '0;
  assign at_term      = (counter == term_value);
  assign step_value   = up ? (counter + ONE) : (counter - ONE);

  // Only a plain +/-1 step landing on the terminal value raises tc.
  always_comb begin
    counter_nxt = counter;
    reload_nxt  = reload;
    tc_nxt      = 1'b0;
    if (load) begin
      counter_nxt = load_clamped;
      reload_nxt  = load_clamped;
    end else if (enable) begin
      if (!at_term) begin
        counter_nxt = step_value;
        tc_nxt      = (step_value == term_value);
      end else begin
        case (mode_s)
          MODE_WRAP:   counter_nxt = up ? '0 : MAX_VALUE;
          MODE_RELOAD: counter_nxt = reload;
          default:     counter_nxt = counter;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter <= RESET_VALUE;
      reload  <= RESET_VALUE;
      tc      <= 1'b0;
    end else begin
      counter <= counter_nxt;
      reload  <= reload_nxt;
      tc      <= tc_nxt;
    end
  end

  assign zero   = (counter == '0);
  assign at_max = (counter == MAX_VALUE);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=4, MAX_VALUE=9) with a queue scoreboard.
module tb_updown_mod_counter;

  logic       clock;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       up;
  logic [1:0] mode;
  logic [3:0] counter;
  logic       zero;
  logic       at_max;
  logic       tc;

  typedef struct {
    string      tag;
    logic [3:0] cnt;
    logic       tc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  updown_mod_counter #(
    .WIDTH(4),
    .MAX_VALUE(4'd9),
    .RESET_VALUE(4'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .enable(enable),
    .up(up),
    .mode(mode),
    .counter(counter),
    .zero(zero),
    .at_max(at_max),
    .tc(tc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want)
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".counter"}, 32'(counter), 32'(e.cnt));
      cmp({e.tag, ".tc"},      32'(tc),      32'(e.tc));
      cmp({e.tag, ".zero"},    32'(zero),    32'(e.cnt == 4'd0));
      cmp({e.tag, ".at_max"},  32'(at_max),  32'(e.cnt == 4'd9));
    end
  endtask

  task automatic step(input string tag, input logic ld, input logic [3:0] lv,
                      input logic en, input logic u, input logic [1:0] m,
                      input logic [3:0] ec, input logic et);
    @(negedge clock);
    load       = ld;
    load_value = lv;
    enable     = en;
    up         = u;
    mode       = m;
    sb.push_back('{tag, ec, et});
    @(posedge clock);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    load_value = 4'd0;
    enable     = 1'b0;
    up         = 1'b0;
    mode       = 2'd0;
    #1;
    sb.push_back('{"reset", 4'd0, 1'b0});
    check_out();
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset in the middle of a count
    step("rst_load7", 1, 4'd7, 0, 0, 2'd0, 4'd7, 0);
    step("rst_dn1",   0, 4'd0, 1, 0, 2'd0, 4'd6, 0);
    step("rst_dn2",   0, 4'd0, 1, 0, 2'd0, 4'd5, 0);
    #3;
    reset = 1'b1;
    sb.push_back('{"async_rst", 4'd0, 1'b0});
    #1;
    check_out();
    @(negedge clock);
    reset = 1'b0;
    // Reload register was also reset, so reloading at 0 yields 0
    step("rst_reload", 0, 4'd0, 1, 0, 2'd2, 4'd0, 0);

    // STOP down
    step("stop_load", 1, 4'd3, 0, 0, 2'd0, 4'd3, 0);
    step("stop_d1",   0, 4'd0, 1, 0, 2'd0, 4'd2, 0);
    step("stop_d2",   0, 4'd0, 1, 0, 2'd0, 4'd1, 0);
    step("stop_d3",   0, 4'd0, 1, 0, 2'd0, 4'd0, 1);
    step("stop_d4",   0, 4'd0, 1, 0, 2'd0, 4'd0, 0);
    step("stop_d5",   0, 4'd0, 1, 0, 2'd0, 4'd0, 0);

    // WRAP up
    step("wrap_load", 1, 4'd8, 0, 1, 2'd1, 4'd8, 0);
    step("wrap_u1",   0, 4'd0, 1, 1, 2'd1, 4'd9, 1);
    step("wrap_u2",   0, 4'd0, 1, 1, 2'd1, 4'd0, 0);
    step("wrap_u3",   0, 4'd0, 1, 1, 2'd1, 4'd1, 0);

    // WRAP down from 0
    step("wrapd_load", 1, 4'd0, 0, 0, 2'd1, 4'd0, 0);
    step("wrapd_d1",   0, 4'd0, 1, 0, 2'd1, 4'd9, 0);

    // RELOAD down
    step("rld_load", 1, 4'd2, 0, 0, 2'd2, 4'd2, 0);
    step("rld_d1",   0, 4'd0, 1, 0, 2'd2, 4'd1, 0);
    step("rld_d2",   0, 4'd0, 1, 0, 2'd2, 4'd0, 1);
    step("rld_d3",   0, 4'd0, 1, 0, 2'd2, 4'd2, 0);
    step("rld_d4",   0, 4'd0, 1, 0, 2'd2, 4'd1, 0);

    // RELOAD up, then enable low holds
    step("rldu_load", 1, 4'd8, 0, 1, 2'd2, 4'd8, 0);
    step("rldu_u1",   0, 4'd0, 1, 1, 2'd2, 4'd9, 1);
    step("rldu_u2",   0, 4'd0, 1, 1, 2'd2, 4'd8, 0);
    step("rldu_hold", 0, 4'd0, 0, 1, 2'd2, 4'd8, 0);

    // STOP up holds at max
    step("stopu_load", 1, 4'd9, 0, 1, 2'd0, 4'd9, 0);
    step("stopu_u1",   0, 4'd0, 1, 1, 2'd0, 4'd9, 0);

    // Clamp and load-over-enable priority
    step("clamp_load", 1, 4'd15, 1, 0, 2'd0, 4'd9, 0);
    step("clamp_d1",   0, 4'd0,  1, 0, 2'd0, 4'd8, 0);

    // Direction change
    step("dir_load", 1, 4'd5, 0, 1, 2'd0, 4'd5, 0);
    step("dir_u1",   0, 4'd0, 1, 1, 2'd0, 4'd6, 0);
    step("dir_d1",   0, 4'd0, 1, 0, 2'd0, 4'd5, 0);
    step("dir_d2",   0, 4'd0, 1, 0, 2'd0, 4'd4, 0);

    // Reserved mode behaves as STOP
    step("rsv_load", 1, 4'd0, 0, 0, 2'd3, 4'd0, 0);
    step("rsv_d1",   0, 4'd0, 1, 0, 2'd3, 4'd0, 0);

    cmp("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised up/down modulo counter, the next generation of the team's 4-bit latch-and-decrement down counter. It adds:
- configurable width and upper bound;
- a per-cycle direction select;
- three terminal-count modes (stop, wrap, auto-reload);
- a registered terminal-count pulse.

It is the general timing and loop-count primitive for control paths that previously instantiated fixed down counters.

## Interface
- WIDTH, 4, counter width in bits (1..32)
- MAX_VALUE, 2**WIDTH-1, upper count bound; legal range 1..2**WIDTH-1
- RESET_VALUE, 0, counter and reload register value after reset; must be ≤ MAX_VALUE
- clock  input  1  rising-edge clock, the only clock of the block
- reset  input  1  asynchronous, active-high reset
- load  input  1  capture load_value into counter and reload register
- load_value  input  WIDTH  value to load; values > MAX_VALUE are clamped to MAX_VALUE
- enable  input  1  count step request
- up  input  1  direction: 1 counts up, 0 counts down
- mode  input  2  terminal behaviour: 0 STOP, 1 WRAP, 2 RELOAD, 3 reserved (behaves as STOP)
- counter  output  WIDTH  current count, registered
- zero  output  1  combinational, high when counter == 0
- at_max  output  1  combinational, high when counter == MAX_VALUE
- tc  output  1  registered one-cycle terminal-count pulse

## Operation
- Reset (asynchronous, any time, including mid-count) forces:
  - counter = RESET_VALUE, reload register = RESET_VALUE, tc = 0;
  - zero and at_max follow from counter.
- Priority per edge: reset > load > enable.
- load: counter <= clamp(load_value) and reload <= clamp(load_value). No step occurs even if enable is high. tc <= 0.
- Terminal value: 0 when up=0, MAX_VALUE when up=1.
- enable with counter not at the terminal value for the current direction: counter steps ±1.
- enable with counter at the terminal value:
  - STOP: hold.
  - WRAP: down 0 -> MAX_VALUE; up MAX_VALUE -> 0.
  - RELOAD: counter <= reload register (independent of direction).
- enable low: hold. mode and up are sampled every edge; a change takes effect on the next edge.
- tc <= 1 on an edge where an enabled ±1 step lands on the terminal value for the current direction, otherwise 0.
  - Wrap and reload transitions and loads never set tc.
  - Holding at terminal in STOP does not re-assert tc.
- Arithmetic is WIDTH-bit unsigned. The counter never exceeds MAX_VALUE, including when MAX_VALUE < 2**WIDTH-1.

## Timing
- Load-to-output latency: 1 cycle. Step latency: 1 cycle per enabled edge.
- tc is high in the same cycle the counter first shows the terminal value, for exactly one cycle.
- zero and at_max are combinational from the counter register; they carry no additional latency.
- Reset deassertion: the first edge after deassertion may load or step normally.
- Full down sequence from load N with continuous enable in STOP mode takes N edges to reach 0. tc is high in the cycle zero first rises.

## Structure
- Shared package counter_pkg holds:
  - mode constants MODE_STOP=2'd0, MODE_WRAP=2'd1, MODE_RELOAD=2'd2;
  - a typedef for the 2-bit mode field.
- Single module; no sub-module. The next-state calculation is one combinational block, and the counter, reload and tc registers are one sequential block with asynchronous reset.
- Target size is 120–250 lines of RTL. Elaboration-time checks assert the MAX_VALUE and RESET_VALUE constraints.

## Test plan
All cases use WIDTH=4 and MAX_VALUE=9 unless stated.
- Reset mid-count: load 7, enable down 2 edges, assert reset asynchronously between edges -> counter=0 and tc=0 immediately, with no clock edge needed.
- STOP down: load 3, mode=0, up=0, enable 5 edges -> counter 2,1,0,0,0; tc high only in the cycle counter first reads 0; zero stays high.
- WRAP up: load 8, mode=1, up=1, enable 3 edges -> counter 9,0,1; tc high only with counter=9; at_max high with counter=9.
- RELOAD down: load 2, mode=2, enable 4 edges -> counter 1,0,2,1; tc pulses once at 0 and not on the reload.
- Clamp and priority: load_value=15 with enable=1 and up=0 on the same edge -> counter=9 with no step; next enabled edge gives 8.
- Direction change: load 5; enable up 1 edge (6), then down 2 edges -> 5,4; tc stays 0 throughout.
